// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN input-unit image loader.
package snn_pkg;

   localparam int         NUM_INPUT_UNITS = 784;
   localparam int         IMG_BYTES       = NUM_INPUT_UNITS / 8;
   localparam logic [7:0] ASCII_ZERO      = 8'h30;

   typedef enum logic [2:0] {
      ST_RECV,
      ST_UNPACK,
      ST_START_CORE,
      ST_WAIT_CORE,
      ST_SEND
   } loader_state_e;

endpackage

// File: rtl/snn_byte_unpacker.sv
// One-byte holding register in front of an LSB-first shift register and
// bit counter; streams a captured byte out as eight single bits.
module snn_byte_unpacker (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_rdy,
   input  logic [7:0] rx_data,
   input  logic       load,
   input  logic       shift_en,
   output logic       full,
   output logic [2:0] bit_cnt,
   output logic       bit_out,
   output logic       done_byte,
   output logic       overrun
);

   logic [7:0] hold_q, hold_d;
   logic       full_q, full_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       overrun_q, overrun_d;

   always_comb begin
      hold_d    = hold_q;
      full_d    = full_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      overrun_d = overrun_q;

      // Emptying on load happens first so a byte arriving in the same cycle is kept.
      if (load) begin
         full_d    = 1'b0;
         shift_d   = hold_q;
         bit_cnt_d = 3'd0;
      end else if (shift_en) begin
         shift_d   = {1'b0, shift_q[7:1]};
         bit_cnt_d = bit_cnt_q + 3'd1;
      end

      if (rx_rdy) begin
         if (!full_d) begin
            full_d = 1'b1;
            hold_d = rx_data;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= 8'd0;
         full_q    <= 1'b0;
         shift_q   <= 8'd0;
         bit_cnt_q <= 3'd0;
         overrun_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         full_q    <= full_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         overrun_q <= overrun_d;
      end
   end

   assign full      = full_q;
   assign bit_cnt   = bit_cnt_q;
   assign bit_out   = shift_q[0];
   assign done_byte = shift_en && (bit_cnt_q == 3'd7);
   assign overrun   = overrun_q;

endmodule

// File: rtl/snn_image_loader.sv
// Unpacks UART image bytes into the 1-bit input-unit RAM, kicks the SNN core
// and returns the classified digit as one ASCII byte.
//
// state         | meaning
// --------------+-----------------------------------------------------
// ST_RECV       | idle, waiting for the holding register to fill
// ST_UNPACK     | 8 cycles, one RAM write per pixel bit
// ST_START_CORE | one-cycle core_start pulse, byte counter cleared
// ST_WAIT_CORE  | waiting for core_done, latch the digit
// ST_SEND       | issue tx_start once the transmitter is free
module snn_image_loader
   import snn_pkg::*;
#(
   parameter int         NUM_BITS   = NUM_INPUT_UNITS,
   parameter logic [7:0] ASCII_BASE = ASCII_ZERO
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_rdy,
   input  logic [7:0] rx_data,
   output logic       ram_we,
   output logic [9:0] ram_addr,
   output logic       ram_d,
   output logic       core_start,
   input  logic       core_done,
   input  logic [3:0] core_digit,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic [3:0] digit,
   output logic       digit_vld,
   output logic       overrun
);

   localparam logic [6:0] LAST_BYTE = 7'(NUM_BITS / 8 - 1);

   loader_state_e state_q, state_d;
   logic [6:0]    byte_cnt_q, byte_cnt_d;
   logic [3:0]    digit_q, digit_d;
   logic          digit_vld_q, digit_vld_d;
   logic [7:0]    tx_data_q, tx_data_d;

   logic       load, shift_en, full, bit_out, done_byte;
   logic [2:0] bit_cnt;

   snn_byte_unpacker u_unpacker (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_rdy    (rx_rdy),
      .rx_data   (rx_data),
      .load      (load),
      .shift_en  (shift_en),
      .full      (full),
      .bit_cnt   (bit_cnt),
      .bit_out   (bit_out),
      .done_byte (done_byte),
      .overrun   (overrun)
   );

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      digit_d     = digit_q;
      digit_vld_d = digit_vld_q;
      tx_data_d   = tx_data_q;
      load        = 1'b0;
      shift_en    = 1'b0;
      ram_we      = 1'b0;
      core_start  = 1'b0;
      tx_start    = 1'b0;

      case (state_q)
         ST_RECV: begin
            if (full) begin
               load    = 1'b1;
               state_d = ST_UNPACK;
            end
         end
         ST_UNPACK: begin
            shift_en = 1'b1;
            ram_we   = 1'b1;
            if (done_byte) begin
               byte_cnt_d = byte_cnt_q + 7'd1;
               state_d    = (byte_cnt_q == LAST_BYTE) ? ST_START_CORE : ST_RECV;
            end
         end
         ST_START_CORE: begin
            core_start = 1'b1;
            byte_cnt_d = 7'd0;
            state_d    = ST_WAIT_CORE;
         end
         ST_WAIT_CORE: begin
            if (core_done) begin
               digit_d     = core_digit;
               digit_vld_d = 1'b1;
               tx_data_d   = ASCII_BASE + {4'd0, core_digit};
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = ST_RECV;
            end
         end
         default: state_d = ST_RECV;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RECV;
         byte_cnt_q  <= 7'd0;
         digit_q     <= 4'd0;
         digit_vld_q <= 1'b0;
         tx_data_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         digit_q     <= digit_d;
         digit_vld_q <= digit_vld_d;
         tx_data_q   <= tx_data_d;
      end
   end

   assign ram_addr  = {byte_cnt_q, bit_cnt};
   assign ram_d     = bit_out;
   assign digit     = digit_q;
   assign digit_vld = digit_vld_q;
   assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_snn_image_loader.sv
// Directed/random bench for snn_image_loader: pixel writes are compared
// against a bit list built from the accepted bytes.
module tb_snn_image_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_rdy = 1'b0;
   logic [7:0] rx_data = 8'd0;
   logic       core_done = 1'b0;
   logic [3:0] core_digit = 4'd0;
   logic       tx_busy = 1'b0;
   logic       ram_we, ram_d, core_start, tx_start, digit_vld, overrun;
   logic [9:0] ram_addr;
   logic [7:0] tx_data;
   logic [3:0] digit;

   snn_image_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_rdy     (rx_rdy),
      .rx_data    (rx_data),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_d      (ram_d),
      .core_start (core_start),
      .core_done  (core_done),
      .core_digit (core_digit),
      .tx_busy    (tx_busy),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .digit      (digit),
      .digit_vld  (digit_vld),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_assert = 0;
   int   n_fail   = 0;
   int   we_in_rst = 0;
   int   wr_addr_q[$];
   logic wr_d_q[$];
   int   wr_cyc_q[$];
   int   cs_cyc_q[$];
   logic exp_pix[$];
   int   last_rx_cyc;

   always @(negedge clk) begin
      if (!rst_n) begin
         if (ram_we !== 1'b0) we_in_rst++;
      end else begin
         if (ram_we === 1'b1) begin
            wr_addr_q.push_back(int'(ram_addr));
            wr_d_q.push_back(ram_d);
            wr_cyc_q.push_back(cyc);
         end
         if (core_start === 1'b1) cs_cyc_q.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic add_byte(input logic [7:0] b);
      for (int k = 0; k < 8; k++) exp_pix.push_back(b[k]);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk); #1;
      rx_rdy = 1'b1;
      rx_data = b;
      last_rx_cyc = cyc;
      @(posedge clk); #1;
      rx_rdy = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic clear_obs();
      wr_addr_q.delete();
      wr_d_q.delete();
      wr_cyc_q.delete();
      cs_cyc_q.delete();
      exp_pix.delete();
   endtask

   // Full image: writes are pixel i at address i, then exactly one core_start
   // in the cycle after the last write and not before the last byte arrived.
   task automatic check_image(input string tag);
      int n;
      chk({tag, " write count"}, wr_addr_q.size(), 784);
      n = (wr_addr_q.size() < exp_pix.size()) ? wr_addr_q.size() : exp_pix.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, " addr"}, wr_addr_q[i], i);
         chk({tag, " data"}, wr_d_q[i], exp_pix[i]);
      end
      chk({tag, " core_start count"}, cs_cyc_q.size(), 1);
      if (cs_cyc_q.size() > 0 && wr_cyc_q.size() > 0) begin
         chk({tag, " core_start timing"}, cs_cyc_q[0], wr_cyc_q[wr_cyc_q.size()-1] + 1);
         chk({tag, " core_start after last byte"}, cs_cyc_q[0] > last_rx_cyc, 1);
      end
      clear_obs();
   endtask

   task automatic classify(input logic [3:0] d, input int busy_cycles);
      logic [7:0] exp_tx;
      int bad;
      exp_tx = 8'h30 + {4'd0, d};
      @(posedge clk); #1;
      core_done = 1'b1;
      core_digit = d;
      tx_busy = (busy_cycles > 0);
      @(posedge clk); #1;
      core_done = 1'b0;
      core_digit = 4'($urandom);
      chk("digit", digit, d);
      chk("digit_vld", digit_vld, 1);
      chk("tx_data", tx_data, exp_tx);
      if (busy_cycles > 0) begin
         bad = 0;
         for (int i = 0; i < busy_cycles; i++) begin
            if (tx_start !== 1'b0 || tx_data !== exp_tx) bad++;
            @(posedge clk); #1;
         end
         chk("tx held while busy", bad, 0);
         tx_busy = 1'b0;
         #1;
      end
      chk("tx_start", tx_start, 1);
      chk("tx_data at start", tx_data, exp_tx);
      @(posedge clk); #1;
      chk("tx_start single", tx_start, 0);
   endtask

   initial begin
      logic [7:0] b;
      int first_rx;

      // Reset values
      #12;
      chk("rst ram_we", ram_we, 0);
      chk("rst ram_addr", ram_addr, 0);
      chk("rst ram_d", ram_d, 0);
      chk("rst core_start", core_start, 0);
      chk("rst tx_start", tx_start, 0);
      chk("rst tx_data", tx_data, 0);
      chk("rst digit", digit, 0);
      chk("rst digit_vld", digit_vld, 0);
      chk("rst overrun", overrun, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      clear_obs();

      // Image 1: 98 x A5, then digit 7 with transmitter idle
      for (int i = 0; i < 98; i++) begin
         send_byte(8'hA5, 18);
         if (i == 0) first_rx = last_rx_cyc;
         add_byte(8'hA5);
      end
      chk("first write latency", (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1, first_rx + 2);
      check_image("img1");
      classify(4'd7, 0);

      // core_done outside WAIT_CORE is ignored
      @(posedge clk); #1;
      core_done = 1'b1;
      core_digit = 4'd3;
      @(posedge clk); #1;
      core_done = 1'b0;
      chk("stray done tx_start", tx_start, 0);
      @(posedge clk); #1;
      chk("stray done digit", digit, 7);
      chk("stray done tx_data", tx_data, 8'h37);

      // Image 2: random bytes, busy transmitter, digit >= 10
      for (int i = 0; i < 98; i++) begin
         b = 8'($urandom);
         send_byte(b, 18);
         add_byte(b);
      end
      check_image("img2");
      classify(4'd12, 50);

      // Image 3: three consecutive bytes during UNPACK, one kept, two dropped
      chk("overrun before", overrun, 0);
      b = 8'($urandom);
      send_byte(b, 0);
      add_byte(b);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         rx_rdy = 1'b1;
         rx_data = b;
         if (i == 0) add_byte(b);
         @(posedge clk); #1;
      end
      rx_rdy = 1'b0;
      chk("overrun set", overrun, 1);
      repeat (15) @(posedge clk);
      for (int i = 0; i < 96; i++) begin
         b = 8'($urandom);
         send_byte(b, 18);
         add_byte(b);
      end
      check_image("img3");
      chk("overrun sticky", overrun, 1);
      classify(4'($urandom_range(0, 9)), 0);
      chk("overrun sticky after send", overrun, 1);

      // Reset part way through an image
      for (int i = 0; i < 40; i++) send_byte(8'($urandom), 18);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid rst ram_we", ram_we, 0);
      chk("mid rst overrun", overrun, 0);
      chk("mid rst digit_vld", digit_vld, 0);
      chk("mid rst tx_data", tx_data, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("no write during reset", we_in_rst, 0);
      clear_obs();
      for (int i = 0; i < 98; i++) begin
         send_byte(8'hFF, 18);
         if (i == 0) first_rx = last_rx_cyc;
         add_byte(8'hFF);
      end
      chk("post rst latency", (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1, first_rx + 2);
      check_image("img4");

      // Back-to-back: first byte of next image arrives with core_done
      b = 8'($urandom);
      @(posedge clk); #1;
      core_done = 1'b1;
      core_digit = 4'd9;
      rx_rdy = 1'b1;
      rx_data = b;
      last_rx_cyc = cyc;
      add_byte(b);
      @(posedge clk); #1;
      core_done = 1'b0;
      rx_rdy = 1'b0;
      chk("b2b tx_start", tx_start, 1);
      chk("b2b tx_data", tx_data, 8'h39);
      chk("b2b digit", digit, 9);
      repeat (15) @(posedge clk);
      chk("b2b first byte writes", wr_addr_q.size(), 8);
      for (int i = 0; i < 97; i++) begin
         b = 8'($urandom);
         send_byte(b, 18);
         add_byte(b);
      end
      check_image("img5");
      chk("b2b overrun", overrun, 0);
      classify(4'($urandom), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/snn_image_loader.md
Name: snn_image_loader

Overview:
- Write side of the input-unit RAM that the SNN core reads bit-serially.
- Accepts the 98-byte (784-pixel, 1 bit/pixel) image from the UART receiver byte handshake and unpacks each byte into eight 1-bit RAM writes.
- Pulses the core's start when the image is complete, waits for its done, latches the classified digit, and sends it as one ASCII byte through the UART transmitter.
- Sits between uart_rx / uart_tx and snn_core + ram_input_unit at the top level.

Parameters:
- NUM_BITS, 784, number of input units / pixels; must be a multiple of 8.
- ASCII_BASE, 8'h30, offset added to the digit before transmit.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_rdy  input  1  one-cycle pulse; rx_data valid this cycle.
- rx_data  input  8  received byte; pixel 8n+k = bit k (LSB first).
- ram_we  output  1  input-unit RAM write enable.
- ram_addr  output  10  input-unit RAM address.
- ram_d  output  1  input-unit RAM write data.
- core_start  output  1  one-cycle start pulse to the SNN core.
- core_done  input  1  core completion pulse.
- core_digit  input  4  core result, valid when core_done=1.
- tx_busy  input  1  UART transmitter busy.
- tx_start  output  1  one-cycle transmit request.
- tx_data  output  8  byte to transmit, held stable from tx_start until the next tx_start.
- digit  output  4  last classified digit, registered.
- digit_vld  output  1  high after the first classification; cleared only by reset.
- overrun  output  1  sticky; a byte was dropped because the holding register was full.

Behaviour:
- Reset values (async, rst_n=0): all outputs 0. State RECV, byte count 0, bit count 0, holding register empty.
- Holding register (1 byte + full flag):
  - Captures rx_data on rx_rdy whenever empty, in any state.
  - rx_rdy while full: byte dropped, overrun set to 1. overrun stays set until reset.
  - Emptied in the cycle UNPACK is entered. A capture in that same cycle is accepted and does not count as an overrun.
- States: RECV, UNPACK, START_CORE, WAIT_CORE, SEND.
- RECV: if holding full, go to UNPACK. The byte moves to a shift register and bit count clears to 0.
- UNPACK: lasts exactly 8 cycles.
  - Each cycle: ram_we=1, ram_d=shift[0], ram_addr=byte_cnt*8+bit_cnt. Then shift right and increment bit_cnt.
  - On bit 7: increment byte_cnt.
  - If byte_cnt was NUM_BITS/8-1 (last address = NUM_BITS-1 = 783), go to START_CORE. Otherwise go to RECV.
  - ram_addr is combinational from the counters. ram_we and ram_d are registered or combinational consistently so that address, data and we align in the same cycle.
- START_CORE: core_start=1 for exactly one cycle; byte_cnt clears to 0; go to WAIT_CORE.
- WAIT_CORE:
  - On core_done: digit<=core_digit, digit_vld<=1, tx_data<=ASCII_BASE+core_digit (8-bit add, no wrap for 0..9). Go to SEND.
  - Bytes of the next image may arrive here; at most one is buffered.
- SEND: when tx_busy=0, tx_start=1 for one cycle, then go to RECV. While tx_busy=1, stay in SEND.
- Latency:
  - rx_rdy to first ram_we: 2 cycles (capture, RECV→UNPACK).
  - Last bit write to core_start: 1 cycle.
  - core_done to tx_start: 1 cycle when tx_busy=0.
- Simultaneous events:
  - core_done together with rx_rdy: both are honoured.
  - core_done outside WAIT_CORE is ignored.
- Values ≥10 on core_digit are transmitted unchecked.
- Reset mid-image discards the partial image. The next byte after reset is pixel 0..7.

Decomposition:
- Package snn_pkg: state typedef for this FSM, NUM_INPUT_UNITS=784, IMG_BYTES=98, ASCII_ZERO=8'h30.
- Natural sub-module: snn_byte_unpacker (holding register + shift register + bit counter, with done_byte output).
- The top FSM and counters stay in snn_image_loader.

Test Plan:
- 98 bytes 8'hA5, spaced 20 cycles apart → 784 writes: ram_d at addr 0..7 = 1,0,1,0,0,1,0,1 pattern repeating. Last write at addr 783. core_start pulses once, 1 cycle after that write.
- After the image, core_done with core_digit=7, tx_busy=0 → digit=7, digit_vld=1, tx_start one cycle later with tx_data=8'h37.
- tx_busy held high 50 cycles at core_done → tx_start delayed until the cycle after tx_busy falls; tx_data stable at 0x30+digit.
- rx_rdy on three consecutive cycles while in UNPACK → first captured, second and third dropped, overrun=1. Overrun stays 1 through a subsequent full image.
- rst_n pulsed low after 40 bytes, then 98 bytes of 8'hFF sent → writes restart at addr 0. core_start fires only after the 98th post-reset byte; no ram_we occurs during reset.
- Back-to-back images, with the first byte of image 2 arriving during WAIT_CORE → the byte is buffered. After SEND, its 8 writes go to addr 0..7 with no overrun.
